mem_burst: RTL and testbench

MEM_BURST -- requirements
Module: mem_burst

---
 rtl/mem_burst.sv | 144 ++++++++++++++
 tb/tb_mem_burst.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst.sv
// Burst-oriented single-port word memory with a command handshake and registered read beats.
// Optional build macro MEM_PARITY_EN adds per-word even parity with injection and read-error flag.
module mem_burst #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_BURST  = 4,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  wvalid,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  rvalid,
    output logic [WIDTH-1:0]      rdata,
`ifdef MEM_PARITY_EN
    input  logic                  par_inj,
    output logic                  rerr,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_rvalid;
    logic [WIDTH-1:0]      r_rdata;
    logic [WIDTH-1:0]      r_mem [DEPTH];
`ifdef MEM_PARITY_EN
    logic                  r_par [DEPTH];
    logic                  r_rerr;
`endif

    logic                  w_accept;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;

    assign w_accept  = valid && ready;
    assign w_last    = (r_cnt == '0);
    assign w_ptr_inc = (r_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;

    // r_run keeps ready low until the first edge after reset release.
    assign ready  = r_run && (r_state == StIdle);
    assign busy   = (r_state != StIdle);
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
`ifdef MEM_PARITY_EN
    assign rerr   = r_rerr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = wr_rd ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (wvalid && w_last) begin
                    w_state_nxt = StIdle;
                end
            end
            StRead: begin
                if (w_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run    <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
`ifdef MEM_PARITY_EN
            r_rerr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
`endif
        end else begin
            r_run    <= 1'b1;
            r_rvalid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ptr <= addr;
                        r_cnt <= len;
                    end
                end
                StWrite: begin
                    if (wvalid) begin
                        r_mem[r_ptr] <= wdata;
`ifdef MEM_PARITY_EN
                        r_par[r_ptr] <= (^wdata) ^ par_inj;
`endif
                        r_ptr <= w_ptr_inc;
                        if (!w_last) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                StRead: begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= r_mem[r_ptr];
`ifdef MEM_PARITY_EN
                    r_rerr   <= (^r_mem[r_ptr]) ^ r_par[r_ptr];
`endif
                    r_ptr    <= w_ptr_inc;
                    if (!w_last) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst.sv
// Scoreboard bench for mem_burst: reads push expected beats, a negedge monitor pops and compares.
// Build with MEM_PARITY_EN defined to also exercise the parity path.
module tb_mem_burst;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       ready;
    logic       wr_rd;
    logic [3:0] addr;
    logic [1:0] len;
    logic       wvalid;
    logic [7:0] wdata;
    logic       rvalid;
    logic [7:0] rdata;
    logic       busy;
`ifdef MEM_PARITY_EN
    logic       par_inj;
    logic       rerr;
`endif

    int         checks;
    int         errors;
    int         beat_cnt;
    int         waited;
    logic [8:0] sb_q [$];
    logic [7:0] m_mem [16];
    logic       m_par [16];

    mem_burst dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .ready  (ready),
        .wr_rd  (wr_rd),
        .addr   (addr),
        .len    (len),
        .wvalid (wvalid),
        .wdata  (wdata),
        .rvalid (rvalid),
        .rdata  (rdata),
`ifdef MEM_PARITY_EN
        .par_inj(par_inj),
        .rerr   (rerr),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst && rvalid) begin
            beat_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected rdata=%0h required=no beat", rdata);
            end else begin
                exp = sb_q.pop_front();
                chk("rdata", {24'd0, rdata}, {24'd0, exp[7:0]});
`ifdef MEM_PARITY_EN
                chk("rerr", {31'd0, rerr}, {31'd0, exp[8]});
`endif
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = 8'd0;
            m_par[i] = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic cmd(input logic w, input logic [3:0] a, input logic [1:0] l, output int n);
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("cmd_ready_timeout", {31'd0, ready}, 32'd1);
        valid = 1'b1;
        wr_rd = w;
        addr  = a;
        len   = l;
        @(negedge clk);
        valid = 1'b0;
        addr  = 4'hF;
        len   = 2'd3;
    endtask

    task automatic write_burst(input logic [3:0] a, input logic [1:0] l, input logic [31:0] d,
                               input int stall_at, input logic flip);
        int n;
        int idx;
        cmd(1'b1, a, l, n);
        for (int i = 0; i <= int'(l); i++) begin
            if (i == stall_at) begin
                wvalid = 1'b0;
                wdata  = 8'hEE;
                repeat (2) @(negedge clk);
            end
            idx    = (int'(a) + i) % 16;
            wvalid = 1'b1;
            wdata  = d[i*8 +: 8];
`ifdef MEM_PARITY_EN
            par_inj = flip;
`endif
            m_mem[idx] = d[i*8 +: 8];
            m_par[idx] = flip;
            @(negedge clk);
        end
        wvalid = 1'b0;
`ifdef MEM_PARITY_EN
        par_inj = 1'b0;
`endif
        chk("write_done_ready", {31'd0, ready}, 32'd1);
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [1:0] l, input logic timing,
                              output int n);
        int idx;
        for (int i = 0; i <= int'(l); i++) begin
            idx = (int'(a) + i) % 16;
            sb_q.push_back({m_par[idx], m_mem[idx]});
        end
        cmd(1'b0, a, l, n);
        if (timing) begin
            chk("rd_not_early", {31'd0, rvalid}, 32'd0);
            chk("rd_busy", {31'd0, busy}, 32'd1);
            for (int i = 0; i <= int'(l); i++) begin
                @(negedge clk);
                chk("rd_beat_valid", {31'd0, rvalid}, 32'd1);
            end
            @(negedge clk);
            chk("rd_end_rvalid", {31'd0, rvalid}, 32'd0);
            chk("rd_end_ready", {31'd0, ready}, 32'd1);
            idx = (int'(a) + int'(l)) % 16;
            chk("rdata_hold", {24'd0, rdata}, {24'd0, m_mem[idx]});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        errors   = 0;
        beat_cnt = 0;
        rst      = 1'b0;
        valid    = 1'b0;
        wr_rd    = 1'b0;
        addr     = 4'd0;
        len      = 2'd0;
        wvalid   = 1'b0;
        wdata    = 8'd0;
`ifdef MEM_PARITY_EN
        par_inj  = 1'b0;
`endif
        model_clear();

        #3;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        @(negedge clk);
        chk("rst_ready_held", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, ready}, 32'd1);

        // Write beats presented in IDLE must not land anywhere.
        wvalid = 1'b1;
        wdata  = 8'hFF;
        repeat (2) @(negedge clk);
        wvalid = 1'b0;

        write_burst(4'd10, 2'd0, 32'd100, -1, 1'b0);
        read_burst(4'd10, 2'd0, 1'b1, waited);

        write_burst(4'd4, 2'd3, {8'd44, 8'd33, 8'd22, 8'd11}, 2, 1'b0);
        read_burst(4'd4, 2'd3, 1'b1, waited);

        write_burst(4'd14, 2'd3, {8'd4, 8'd3, 8'd2, 8'd1}, -1, 1'b0);
        read_burst(4'd14, 2'd3, 1'b1, waited);
        read_burst(4'd0, 2'd1, 1'b1, waited);
        read_burst(4'd8, 2'd0, 1'b1, waited);

        // Back-to-back reads: the second is taken in the first IDLE cycle.
        beat_cnt = 0;
        read_burst(4'd4, 2'd1, 1'b0, waited);
        read_burst(4'd6, 2'd1, 1'b0, waited);
        chk("b2b_wait_cycles", waited, 32'd2);
        wait_drain();
        chk("b2b_beats", beat_cnt, 32'd4);

        // Reset after two of four read beats.
        beat_cnt = 0;
        for (int i = 0; i < 4; i++) sb_q.push_back({1'b0, m_mem[4 + i]});
        cmd(1'b0, 4'd4, 2'd3, waited);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rdata", {24'd0, rdata}, 32'd0);
        sb_q.delete();
        model_clear();
        @(negedge clk);
        chk("abort_rvalid_held", {31'd0, rvalid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_release_ready", {31'd0, ready}, 32'd1);
        chk("abort_release_busy", {31'd0, busy}, 32'd0);
        chk("abort_beats", beat_cnt, 32'd2);
        read_burst(4'd4, 2'd0, 1'b1, waited);

`ifdef MEM_PARITY_EN
        write_burst(4'd3, 2'd0, 32'h5A, -1, 1'b1);
        read_burst(4'd3, 2'd0, 1'b1, waited);
        write_burst(4'd5, 2'd0, 32'h33, -1, 1'b0);
        read_burst(4'd5, 2'd0, 1'b1, waited);
`endif

        wait_drain();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
